// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the program counter, fetches instruction words over
// a req/ack handshake and presents one opcode/literal per instruction with a
// single-cycle issue strobe.
//
// Optional feature macro: FETCH_JUMP_EN
//   defined   - JMP/JEQ/JNE opcodes redirect the PC using status[0] (Z flag)
//   undefined - next PC is always pc+1 and the status port is unused
//
// state  | meaning
// IDLE   | not fetching, waiting for run
// FETCH  | im_req high, im_addr=pc, waiting for im_ack
// ISSUE  | instr_valid high, opcode/literal from instruction register
// HALT   | HALT retired, only reset leaves
module instruction_fetch #(
  parameter int PC_W = 8,
  parameter int K_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  input  logic            im_ack,
  input  logic [K_W+6:0]  im_data,
  input  logic [3:0]      status,
  output logic [6:0]      opcode,
  output logic [K_W-1:0]  literal,
  output logic            instr_valid,
  output logic            halted,
  output logic [PC_W-1:0] pc
);

  localparam logic [6:0] OP_BUBBLE = 7'b1111110;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] next_pc;
  logic [K_W+6:0]  ir_q, ir_d;
  logic [6:0]      ir_op;
  logic [K_W-1:0]  ir_lit;

  assign ir_op  = ir_q[K_W+6:K_W];
  assign ir_lit = ir_q[K_W-1:0];

`ifdef FETCH_JUMP_EN
  localparam logic [6:0] OP_JMP = 7'b1000000;
  localparam logic [6:0] OP_JEQ = 7'b1000001;
  localparam logic [6:0] OP_JNE = 7'b1000010;

  // Only the Z flag steers jumps; the other flags are carried for the datapath.
  logic unused_status;
  assign unused_status = ^status[3:1];

  // Successor PC: sequential, or the literal when a jump is taken.
  always_comb begin
    next_pc = pc_q + PC_W'(1);
    case (ir_op)
      OP_JMP:  next_pc = PC_W'(ir_lit);
      OP_JEQ:  if (status[0])  next_pc = PC_W'(ir_lit);
      OP_JNE:  if (!status[0]) next_pc = PC_W'(ir_lit);
      default: next_pc = pc_q + PC_W'(1);
    endcase
  end
`else
  logic unused_status;
  assign unused_status = ^status;

  assign next_pc = pc_q + PC_W'(1);
`endif

  // State, program counter and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state: run is only looked at in IDLE and when leaving ISSUE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (im_ack) begin
          ir_d    = im_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ir_op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          pc_d    = next_pc;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state; bubble opcode whenever not issuing.
  always_comb begin
    im_req      = (state_q == S_FETCH);
    instr_valid = (state_q == S_ISSUE);
    halted      = (state_q == S_HALT);
    opcode      = OP_BUBBLE;
    literal     = '0;
    if (state_q == S_ISSUE) begin
      opcode  = ir_op;
      literal = ir_lit;
    end
  end

  assign im_addr = pc_q;
  assign pc      = pc_q;

endmodule
